// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences one latch-to-latch (or immediate-to-latch) transfer
// on the shared 8-bit CPU data bus. The source drives the bus for SETTLE cycles,
// the destination LE is pulsed for one cycle, and the source holds one more
// cycle before release. At most one driver is enabled at any time, and every
// transfer ends with a cycle in which all drivers are released.
module bus_xfer_ctrl #(
  parameter int NREG   = 4,
  parameter int SETTLE = 1
) (
  input  logic                      CLK,
  input  logic                      CLRn,
  input  logic                      REQ,
  input  logic [$clog2(NREG)-1:0]   SRC,
  input  logic [$clog2(NREG)-1:0]   DST,
  input  logic                      IMM_SEL,
  input  logic [7:0]                IMM,
  input  logic [7:0]                BUS,
  output logic [7:0]                IMM_OUT,
  output logic                      IMM_OEn,
  output logic [NREG-1:0]           OEn,
  output logic [NREG-1:0]           LE,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR,
  output logic [7:0]                LAST
);

  localparam int IW = $clog2(NREG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Decode a latch index into a one-hot NREG-wide vector.
  function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_accept;
  logic            w_reject;
  logic            w_bad;

  logic [IW-1:0]   r_src;
  logic [IW-1:0]   r_dst;
  logic            r_isel;
  logic [7:0]      r_imm;

  logic [IW-1:0]   w_src_cur;
  logic [IW-1:0]   w_dst_cur;
  logic            w_isel_cur;
  logic [7:0]      w_imm_cur;

  logic [NREG-1:0] r_oen;
  logic [NREG-1:0] r_le;
  logic            r_imm_oen;
  logic [7:0]      r_imm_out;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [7:0]      r_last;

  logic [NREG-1:0] w_oen_nxt;
  logic [NREG-1:0] w_le_nxt;
  logic            w_imm_oen_nxt;
  logic [7:0]      w_imm_out_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_err_nxt;

  // Request validity. For an immediate load SRC is ignored, so it can neither
  // collide with DST nor be out of range.
  assign w_bad = (!IMM_SEL && (SRC == DST)) ||
                 (!IMM_SEL && (32'(SRC) >= 32'(NREG))) ||
                 (32'(DST) >= 32'(NREG));

  // Outputs are registered from the next state, so on the accepting edge the
  // live request fields are used; afterwards only the captured copies matter.
  assign w_src_cur  = w_accept ? SRC     : r_src;
  assign w_dst_cur  = w_accept ? DST     : r_dst;
  assign w_isel_cur = w_accept ? IMM_SEL : r_isel;
  assign w_imm_cur  = w_accept ? IMM     : r_imm;

  // State and settle-counter register.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: accept or reject in IDLE, count down settle in DRIVE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (REQ) begin
          if (w_bad) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = 4'(SETTLE - 1);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_LATCH;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_LATCH: w_state_nxt = ST_HOLD;
      ST_HOLD:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request fields on acceptance so later input changes are inert.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_isel <= 1'b0;
      r_imm  <= 8'd0;
    end else if (w_accept) begin
      r_src  <= SRC;
      r_dst  <= DST;
      r_isel <= IMM_SEL;
      r_imm  <= IMM;
    end else begin
      r_src  <= r_src;
      r_dst  <= r_dst;
      r_isel <= r_isel;
      r_imm  <= r_imm;
    end
  end

  // Output decode from the next state; exactly one source enabled while busy.
  always_comb begin
    w_oen_nxt     = {NREG{1'b1}};
    w_le_nxt      = {NREG{1'b0}};
    w_imm_oen_nxt = 1'b1;
    w_imm_out_nxt = r_imm_out;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = w_reject;
    case (w_state_nxt)
      ST_DRIVE, ST_LATCH, ST_HOLD: begin
        w_busy_nxt = 1'b1;
        if (w_isel_cur) begin
          w_imm_oen_nxt = 1'b0;
          w_imm_out_nxt = w_imm_cur;
        end else begin
          w_oen_nxt = ~onehot(w_src_cur);
        end
        if (w_state_nxt == ST_LATCH) begin
          w_le_nxt = onehot(w_dst_cur);
        end else begin
          w_le_nxt = {NREG{1'b0}};
        end
      end
      ST_IDLE: begin
        w_done_nxt = (r_state == ST_HOLD);
      end
      default: begin
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Output registers; reset releases every enable asynchronously.
  always_ff @(posedge CLK or negedge CLRn) begin
    if (!CLRn) begin
      r_oen     <= {NREG{1'b1}};
      r_le      <= {NREG{1'b0}};
      r_imm_oen <= 1'b1;
      r_imm_out <= 8'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_last    <= 8'd0;
    end else begin
      r_oen     <= w_oen_nxt;
      r_le      <= w_le_nxt;
      r_imm_oen <= w_imm_oen_nxt;
      r_imm_out <= w_imm_out_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      if (r_state == ST_LATCH) begin
        r_last <= BUS;
      end else begin
        r_last <= r_last;
      end
    end
  end

  assign OEn     = r_oen;
  assign LE      = r_le;
  assign IMM_OEn = r_imm_oen;
  assign IMM_OUT = r_imm_out;
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign ERR     = r_err;
  assign LAST    = r_last;

endmodule
